// File: rtl/hamming_pkg.sv
// Shared types and constants for the Hamming(15,11) transmit path.
// Build option HAMMING_EXT_PARITY_EN adds the overall SECDED parity bit c16.
package hamming_pkg;

    typedef enum logic [1:0] {
        CLEAR  = 2'd0,
        LOAD   = 2'd1,
        ENCODE = 2'd2,
        SEND   = 2'd3
    } state_e;

    localparam int DATA_W = 11;

`ifdef HAMMING_EXT_PARITY_EN
    localparam int CW_W  = 16;
    localparam int CNT_W = 5;
`else
    localparam int CW_W  = 15;
    localparam int CNT_W = 4;
`endif

    // Codeword position (1-based) of each data bit d0..d10.
    localparam int DATA_POS [DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};

    // Parity bits live at positions 1,2,4,8; each covers the data bits in its mask.
    localparam int PAR_POS [4] = '{1, 2, 4, 8};
    localparam logic [DATA_W-1:0] PAR_MASK [4] = '{
        11'b101_0101_1011,  // p1: d0 d1 d3 d4 d6 d8 d10
        11'b110_0110_1101,  // p2: d0 d2 d3 d5 d6 d9 d10
        11'b111_1000_1110,  // p4: d1 d2 d3 d7 d8 d9 d10
        11'b111_1111_0000   // p8: d4..d10
    };

endpackage

// File: rtl/hamming_parity_15_11.sv
// Combinational mapper from 11 data bits to the Hamming codeword (c1 at bit 0).
// With HAMMING_EXT_PARITY_EN the overall parity c16 is appended at bit 15.
module hamming_parity_15_11
    import hamming_pkg::*;
#(
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic [DATA_W-1:0] data_i,
    output logic [CW_W-1:0]   cw_o
);

    logic [14:0] base;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_data
            assign base[DATA_POS[gi]-1] = data_i[gi];
        end
        for (gi = 0; gi < 4; gi++) begin : g_par
            assign base[PAR_POS[gi]-1] = (^(data_i & PAR_MASK[gi])) ^ ODD_PARITY;
        end
    endgenerate

`ifdef HAMMING_EXT_PARITY_EN
    assign cw_o = {(^base) ^ ODD_PARITY, base};
`else
    assign cw_o = base;
`endif

endmodule

// File: rtl/hamming_encoder_ctrl.sv
// Hamming transmit sequencer: collects 11 serial bits via the external shift register,
// encodes, then serialises c1 first. Build option HAMMING_EXT_PARITY_EN sends c16 too.
module hamming_encoder_ctrl
    import hamming_pkg::*;
#(
    parameter bit OUT_IDLE   = 1'b0,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_bit,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              sr_in,
    output logic              sr_shift,
    output logic              sr_clear,
    input  logic [DATA_W-1:0] sr_q,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(CW_W - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CW_W-1:0]  tx_q;
    logic [CW_W-1:0]  cw;
    logic             in_ready_q;
    logic             sr_clear_q;
    logic             out_valid_q;
    logic             out_bit_q;
    logic             out_last_q;
    logic             in_accept;
    logic             out_accept;

    // sr_q is stable during ENCODE because the last shift happened on the edge entering it.
    hamming_parity_15_11 #(
        .ODD_PARITY(ODD_PARITY)
    ) u_parity (
        .data_i(sr_q),
        .cw_o  (cw)
    );

    assign in_accept  = in_valid & in_ready_q;
    assign out_accept = out_valid_q & out_ready;
    assign cnt_d      = cnt_q + CNT_W'(1);

    assign in_ready  = in_ready_q;
    assign sr_in     = in_bit;
    assign sr_shift  = in_accept;
    assign sr_clear  = sr_clear_q;
    assign out_valid = out_valid_q;
    assign out_bit   = out_bit_q;
    assign out_last  = out_last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            tx_q        <= '0;
            in_ready_q  <= 1'b0;
            sr_clear_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_bit_q   <= OUT_IDLE;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    state_q    <= LOAD;
                    cnt_q      <= '0;
                    sr_clear_q <= 1'b0;
                    in_ready_q <= 1'b1;
                end
                LOAD: begin
                    if (in_accept) begin
                        if (cnt_q == LOAD_LAST) begin
                            state_q    <= ENCODE;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                ENCODE: begin
                    state_q     <= SEND;
                    tx_q        <= cw;
                    cnt_q       <= '0;
                    out_valid_q <= 1'b1;
                    out_bit_q   <= cw[0];
                    out_last_q  <= 1'b0;
                end
                SEND: begin
                    if (out_accept) begin
                        if (cnt_q == SEND_LAST) begin
                            state_q     <= CLEAR;
                            cnt_q       <= '0;
                            sr_clear_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_bit_q   <= OUT_IDLE;
                            out_last_q  <= 1'b0;
                        end else begin
                            cnt_q      <= cnt_d;
                            out_bit_q  <= tx_q[cnt_d];
                            out_last_q <= (cnt_d == SEND_LAST);
                        end
                    end
                end
                default: begin
                    state_q <= CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hamming_encoder_ctrl.sv
// Scoreboard bench for hamming_encoder_ctrl: an even-parity and an odd-parity instance
// share stimulus; each owns a model of the external 11-bit shift register.
module tb_hamming_encoder_ctrl;

`ifdef HAMMING_EXT_PARITY_EN
    localparam int CW_N = 16;
`else
    localparam int CW_N = 15;
`endif
    localparam logic OUT_IDLE = 1'b0;

    typedef struct {
        logic b;
        logic bo;
        logic last;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_bit = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;

    logic in_ready, sr_in, sr_shift, sr_clear, out_bit, out_valid, out_last;
    logic in_ready_o, sr_in_o, sr_shift_o, sr_clear_o, out_bit_o, out_valid_o, out_last_o;
    logic [10:0] sr_model, sr_model_o;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    hamming_encoder_ctrl #(.OUT_IDLE(OUT_IDLE), .ODD_PARITY(1'b0)) dut (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
        .sr_in(sr_in), .sr_shift(sr_shift), .sr_clear(sr_clear), .sr_q(sr_model),
        .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
    );

    hamming_encoder_ctrl #(.OUT_IDLE(OUT_IDLE), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .reset(reset), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready_o),
        .sr_in(sr_in_o), .sr_shift(sr_shift_o), .sr_clear(sr_clear_o), .sr_q(sr_model_o),
        .out_bit(out_bit_o), .out_valid(out_valid_o), .out_ready(out_ready), .out_last(out_last_o)
    );

    // External serial-in shift registers: new bit enters at [10], so d0 ends at [0].
    always @(posedge clk) begin
        if (sr_clear) sr_model <= '0;
        else if (sr_shift) sr_model <= {sr_in, sr_model[10:1]};
        if (sr_clear_o) sr_model_o <= '0;
        else if (sr_shift_o) sr_model_o <= {sr_in_o, sr_model_o[10:1]};
    end

    // Positional Hamming model: parity at power-of-two positions covers positions sharing that bit.
    function automatic logic [15:0] encode(input logic [10:0] d, input bit odd);
        logic [15:0] c;
        logic        x;
        int          di;
        c  = '0;
        di = 0;
        for (int k = 1; k <= 15; k++) begin
            if ((k & (k - 1)) != 0) begin
                c[k-1] = d[di];
                di++;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            x = odd;
            for (int k = 1; k <= 15; k++)
                if (((k & p) != 0) && (k != p)) x = x ^ c[k-1];
            c[p-1] = x;
        end
        c[15] = odd ^ (^c[14:0]);
        return c;
    endfunction

    // Output monitor: each bit about to be accepted is popped from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output got bit=%b last=%b, required none", out_bit, out_last);
            end else begin
                e = sb.pop_front();
                if (out_bit !== e.b || out_bit_o !== e.bo || out_last !== e.last ||
                    out_valid_o !== 1'b1 || out_last_o !== e.last || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL out_bit got bit=%b odd=%b last=%b oddlast=%b in_ready=%b, required bit=%b odd=%b last=%b in_ready=0",
                             out_bit, out_bit_o, out_last, out_last_o, in_ready, e.b, e.bo, e.last);
                end
            end
        end
    end

    task automatic put_bit(input logic b);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_bit   = b;
        for (int k = 0; k < 60 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL input_accept_timeout got in_ready=0, required 1");
        end
    endtask

    task automatic send_frame(input logic [10:0] d);
        logic [15:0] c, co;
        for (int i = 0; i < 11; i++) put_bit(d[i]);
        in_valid = 1'b0;
        c  = encode(d, 1'b0);
        co = encode(d, 1'b1);
        for (int i = 0; i < CW_N; i++) sb.push_back('{b: c[i], bo: co[i], last: (i == CW_N - 1)});
    endtask

    task automatic drain(input string tag);
        int k;
        out_ready = 1'b1;
        for (k = 0; k < 100 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got %0d bits pending, required 0", tag, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, sr_clear, sr_shift, out_valid, out_last, out_bit} !== {5'b01000, OUT_IDLE}) begin
            errors++;
            $display("FAIL reset_values got rdy=%b clr=%b sh=%b vld=%b last=%b bit=%b, required 0 1 0 0 0 %b",
                     in_ready, sr_clear, sr_shift, out_valid, out_last, out_bit, OUT_IDLE);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || sr_clear !== 1'b0) begin
            errors++;
            $display("FAIL reset_to_load got in_ready=%b sr_clear=%b, required 1 0", in_ready, sr_clear);
        end
    endtask

    task automatic test_all_ones();
        out_ready = 1'b1;
        send_frame(11'h7FF);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL encode_cycle got out_valid=%b in_ready=%b, required 0 0", out_valid, in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL latency got out_valid=%b two cycles after accept, required 1", out_valid);
        end
        drain("all_ones");
        checks++;
        if (sr_clear !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_bit !== OUT_IDLE) begin
            errors++;
            $display("FAIL post_frame_clear got clr=%b rdy=%b vld=%b bit=%b, required 1 0 0 %b",
                     sr_clear, in_ready, out_valid, out_bit, OUT_IDLE);
        end
        @(posedge clk);
        #1;
        checks++;
        if (sr_clear !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_one_cycle got clr=%b rdy=%b, required 0 1", sr_clear, in_ready);
        end
    endtask

    task automatic test_d0_only();
        out_ready = 1'b1;
        send_frame(11'h001);
        drain("d0_only");
    endtask

    task automatic test_stall();
        logic pv, pr, pb, pl;
        out_ready = 1'b0;
        send_frame(11'b101_1001_0110);
        pv = out_valid;
        pr = out_ready;
        pb = out_bit;
        pl = out_last;
        for (int k = 0; k < 300 && sb.size() != 0; k++) begin
            @(posedge clk);
            #1;
            if (pv && !pr) begin
                checks++;
                if (out_valid !== 1'b1 || out_bit !== pb || out_last !== pl || in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold got vld=%b bit=%b last=%b rdy=%b, required 1 %b %b 0",
                             out_valid, out_bit, out_last, in_ready, pb, pl);
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            pv = out_valid;
            pr = out_ready;
            pb = out_bit;
            pl = out_last;
        end
        drain("stall");
    endtask

    task automatic test_reset_mid_frame();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) put_bit(1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, sr_clear, out_valid, out_last, out_bit} !== {4'b0100, OUT_IDLE}) begin
            errors++;
            $display("FAIL mid_reset_values got rdy=%b clr=%b vld=%b last=%b bit=%b, required 0 1 0 0 %b",
                     in_ready, sr_clear, out_valid, out_last, out_bit, OUT_IDLE);
        end
        reset = 1'b0;
        send_frame(11'h7FF);
        drain("after_reset");
    endtask

    task automatic test_back_to_back();
        logic [10:0] d;
        for (int f = 0; f < 4; f++) begin
            d = 11'($urandom);
            out_ready = 1'b1;
            send_frame(d);
            drain("back_to_back");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_all_ones();
        test_d0_only();
        test_stall();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
